// File: rtl/axil_dpic_pkg.sv
// axil_dpic_pkg: response codes, FSM state types, window decode and the pmem backing-store
// routines shared by the AXI4-Lite memory model.
package axil_dpic_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;

    // Word-addressed store behind pmem_read / pmem_write; the call counters expose traffic.
    bit [31:0]   pmem_mem [bit [29:0]];
    int unsigned pmem_rd_calls;
    int unsigned pmem_wr_calls;

    function automatic logic [31:0] pmem_peek(input logic [31:0] addr);
        return pmem_mem.exists(addr[31:2]) ? pmem_mem[addr[31:2]] : 32'h0;
    endfunction

    function automatic logic [31:0] pmem_read(input logic [31:0] raddr);
        pmem_rd_calls = pmem_rd_calls + 1;
        return pmem_peek(raddr);
    endfunction

    function automatic void pmem_write(input logic [31:0] waddr, input logic [31:0] wdata,
                                       input logic [3:0] wmask);
        bit [31:0] word;
        word = pmem_peek(waddr);
        for (int b = 0; b < 4; b++) begin
            if (wmask[b]) word[b*8 +: 8] = wdata[b*8 +: 8];
        end
        pmem_mem[waddr[31:2]] = word;
        pmem_wr_calls = pmem_wr_calls + 1;
    endfunction

    function automatic logic in_range(input logic [63:0] addr, input logic [63:0] base,
                                      input logic [63:0] size);
        return (addr >= base) && (addr < base + size);
    endfunction

endpackage

// File: rtl/axil_dpic_mem.sv
// axil_dpic_mem: AXI4-Lite slave memory model backed by pmem_read / pmem_write, with
// independent AW/W capture, programmable latencies and an address window that answers SLVERR.
module axil_dpic_mem
    import axil_dpic_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter logic [ADDR_WIDTH-1:0] MEM_SIZE   = 32'h0800_0000,
    parameter int unsigned           RD_LATENCY = 1,
    parameter int unsigned           WR_LATENCY = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    ioAXI_aw_valid,
    output logic                    ioAXI_aw_ready,
    input  logic [ADDR_WIDTH-1:0]   ioAXI_aw_addr,
    input  logic [2:0]              ioAXI_aw_prot,
    input  logic                    ioAXI_w_valid,
    output logic                    ioAXI_w_ready,
    input  logic [DATA_WIDTH-1:0]   ioAXI_w_data,
    input  logic [DATA_WIDTH/8-1:0] ioAXI_w_strb,
    output logic                    ioAXI_b_valid,
    input  logic                    ioAXI_b_ready,
    output logic [1:0]              ioAXI_b_resp,
    input  logic                    ioAXI_ar_valid,
    output logic                    ioAXI_ar_ready,
    input  logic [ADDR_WIDTH-1:0]   ioAXI_ar_addr,
    input  logic [2:0]              ioAXI_ar_prot,
    output logic                    ioAXI_r_valid,
    input  logic                    ioAXI_r_ready,
    output logic [DATA_WIDTH-1:0]   ioAXI_r_data,
    output logic [1:0]              ioAXI_r_resp
);

    localparam int unsigned           STRB_WIDTH = DATA_WIDTH / 8;
    localparam int                    NWORDS     = DATA_WIDTH / 32;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

    wstate_t                 wstate, wstate_next;
    rstate_t                 rstate, rstate_next;
    logic                    aw_held, w_held;
    logic [ADDR_WIDTH-1:0]   aw_addr_hold;
    logic [DATA_WIDTH-1:0]   w_data_hold;
    logic [STRB_WIDTH-1:0]   w_strb_hold;
    logic [15:0]             wcnt, rcnt;
    logic [1:0]              b_resp, r_resp;
    logic [DATA_WIDTH-1:0]   r_data;

    logic                    aw_fire, w_fire, ar_fire, commit, cmt_ok, rd_ok;
    logic [ADDR_WIDTH-1:0]   cmt_addr, rd_addr;
    logic [DATA_WIDTH-1:0]   cmt_data;
    logic [STRB_WIDTH-1:0]   cmt_strb;
    logic                    unused_prot;

    assign unused_prot = ^{ioAXI_aw_prot, ioAXI_ar_prot};

    assign ioAXI_aw_ready = !reset && (wstate == W_IDLE) && !aw_held;
    assign ioAXI_w_ready  = !reset && (wstate == W_IDLE) && !w_held;
    assign ioAXI_ar_ready = !reset && (rstate == R_IDLE);
    assign ioAXI_b_valid  = !reset && (wstate == W_RESP);
    assign ioAXI_r_valid  = !reset && (rstate == R_DATA);
    assign ioAXI_b_resp   = b_resp;
    assign ioAXI_r_resp   = r_resp;
    assign ioAXI_r_data   = r_data;

    assign aw_fire = ioAXI_aw_valid && ioAXI_aw_ready;
    assign w_fire  = ioAXI_w_valid && ioAXI_w_ready;
    assign ar_fire = ioAXI_ar_valid && ioAXI_ar_ready;

    // A commit uses whichever half is already held and the live bus for the other.
    assign commit   = (wstate == W_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);
    assign cmt_addr = (aw_held ? aw_addr_hold : ioAXI_aw_addr) & ALIGN_MASK;
    assign cmt_data = w_held ? w_data_hold : ioAXI_w_data;
    assign cmt_strb = w_held ? w_strb_hold : ioAXI_w_strb;
    assign cmt_ok   = in_range(64'(cmt_addr), 64'(BASE_ADDR), 64'(MEM_SIZE));

    assign rd_addr = ioAXI_ar_addr & ALIGN_MASK;
    assign rd_ok   = in_range(64'(rd_addr), 64'(BASE_ADDR), 64'(MEM_SIZE));

    always_comb begin
        wstate_next = wstate;
        case (wstate)
            W_IDLE:  if (commit) wstate_next = W_WAIT;
            W_WAIT:  if (wcnt == 16'd0) wstate_next = W_RESP;
            W_RESP:  if (ioAXI_b_ready) wstate_next = W_IDLE;
            default: wstate_next = W_IDLE;
        endcase

        rstate_next = rstate;
        case (rstate)
            R_IDLE:  if (ar_fire) rstate_next = R_WAIT;
            R_WAIT:  if (rcnt == 16'd0) rstate_next = R_DATA;
            R_DATA:  if (ioAXI_r_ready) rstate_next = R_IDLE;
            default: rstate_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wstate       <= W_IDLE;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_addr_hold <= '0;
            w_data_hold  <= '0;
            w_strb_hold  <= '0;
            wcnt         <= '0;
            b_resp       <= RESP_OKAY;
            rstate       <= R_IDLE;
            rcnt         <= '0;
            r_resp       <= RESP_OKAY;
            r_data       <= '0;
        end else begin
            wstate <= wstate_next;
            rstate <= rstate_next;

            // Write path first so a read handshaking on the commit edge sees the new data.
            if (commit) begin
                if (cmt_ok) begin
                    for (int i = 0; i < NWORDS; i++) begin
                        if (cmt_strb[i*4 +: 4] != 4'b0) begin
                            pmem_write(32'(cmt_addr) + 32'(4 * i), cmt_data[i*32 +: 32],
                                       cmt_strb[i*4 +: 4]);
                        end
                    end
                end
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                wcnt    <= 16'(WR_LATENCY - 1);
                b_resp  <= cmt_ok ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (aw_fire) begin
                    aw_held      <= 1'b1;
                    aw_addr_hold <= ioAXI_aw_addr;
                end
                if (w_fire) begin
                    w_held      <= 1'b1;
                    w_data_hold <= ioAXI_w_data;
                    w_strb_hold <= ioAXI_w_strb;
                end
            end
            if ((wstate == W_WAIT) && (wcnt != 16'd0)) wcnt <= wcnt - 16'd1;

            if (ar_fire) begin
                r_data <= '0;
                if (rd_ok) begin
                    for (int i = 0; i < NWORDS; i++) begin
                        r_data[i*32 +: 32] <= pmem_read(32'(rd_addr) + 32'(4 * i));
                    end
                end
                r_resp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                rcnt   <= 16'(RD_LATENCY - 1);
            end
            if ((rstate == R_WAIT) && (rcnt != 16'd0)) rcnt <= rcnt - 16'd1;
        end
    end

endmodule

// File: tb/tb_axil_dpic_mem.sv
// tb_axil_dpic_mem: directed vector table plus hand sequences for latency, ordering,
// reset and 64-bit behaviour of axil_dpic_mem.
module tb_axil_dpic_mem;
    import axil_dpic_pkg::*;

    logic        clock;
    logic        reset;
    logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
    logic        ar_valid, ar_ready, r_valid, r_ready;
    logic [31:0] aw_addr, ar_addr, w_data, r_data;
    logic [3:0]  w_strb;
    logic [1:0]  b_resp, r_resp;

    logic        x_aw_valid, x_aw_ready, x_w_valid, x_w_ready, x_b_valid, x_b_ready;
    logic        x_ar_valid, x_ar_ready, x_r_valid, x_r_ready;
    logic [31:0] x_aw_addr, x_ar_addr;
    logic [63:0] x_w_data, x_r_data;
    logic [7:0]  x_w_strb;
    logic [1:0]  x_b_resp, x_r_resp;

    int          n_vectors;
    int          n_miscompares;

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
        int          exp_wr_inc;
        int          exp_rd_inc;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    axil_dpic_mem #(
        .DATA_WIDTH (32),
        .RD_LATENCY (3),
        .WR_LATENCY (2)
    ) u_dut32 (
        .clock          (clock),
        .reset          (reset),
        .ioAXI_aw_valid (aw_valid),
        .ioAXI_aw_ready (aw_ready),
        .ioAXI_aw_addr  (aw_addr),
        .ioAXI_aw_prot  (3'b000),
        .ioAXI_w_valid  (w_valid),
        .ioAXI_w_ready  (w_ready),
        .ioAXI_w_data   (w_data),
        .ioAXI_w_strb   (w_strb),
        .ioAXI_b_valid  (b_valid),
        .ioAXI_b_ready  (b_ready),
        .ioAXI_b_resp   (b_resp),
        .ioAXI_ar_valid (ar_valid),
        .ioAXI_ar_ready (ar_ready),
        .ioAXI_ar_addr  (ar_addr),
        .ioAXI_ar_prot  (3'b000),
        .ioAXI_r_valid  (r_valid),
        .ioAXI_r_ready  (r_ready),
        .ioAXI_r_data   (r_data),
        .ioAXI_r_resp   (r_resp)
    );

    axil_dpic_mem #(
        .DATA_WIDTH (64)
    ) u_dut64 (
        .clock          (clock),
        .reset          (reset),
        .ioAXI_aw_valid (x_aw_valid),
        .ioAXI_aw_ready (x_aw_ready),
        .ioAXI_aw_addr  (x_aw_addr),
        .ioAXI_aw_prot  (3'b000),
        .ioAXI_w_valid  (x_w_valid),
        .ioAXI_w_ready  (x_w_ready),
        .ioAXI_w_data   (x_w_data),
        .ioAXI_w_strb   (x_w_strb),
        .ioAXI_b_valid  (x_b_valid),
        .ioAXI_b_ready  (x_b_ready),
        .ioAXI_b_resp   (x_b_resp),
        .ioAXI_ar_valid (x_ar_valid),
        .ioAXI_ar_ready (x_ar_ready),
        .ioAXI_ar_addr  (x_ar_addr),
        .ioAXI_ar_prot  (3'b000),
        .ioAXI_r_valid  (x_r_valid),
        .ioAXI_r_ready  (x_r_ready),
        .ioAXI_r_data   (x_r_data),
        .ioAXI_r_resp   (x_r_resp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vectors = n_vectors + 1;
        if (act !== exp) begin
            n_miscompares = n_miscompares + 1;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp, output logic ok);
        logic aw_done, w_done, b_done;
        aw_done = 1'b0;
        w_done  = 1'b0;
        b_done  = 1'b0;
        resp    = 2'b11;
        aw_addr = addr;
        w_data  = data;
        w_strb  = strb;
        aw_valid = 1'b1;
        w_valid  = 1'b1;
        for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
            logic aw_f, w_f;
            aw_f = aw_valid && aw_ready;
            w_f  = w_valid && w_ready;
            @(negedge clock);
            if (aw_f) begin aw_done = 1'b1; aw_valid = 1'b0; end
            if (w_f) begin w_done = 1'b1; w_valid = 1'b0; end
        end
        aw_valid = 1'b0;
        w_valid  = 1'b0;
        b_ready  = 1'b1;
        for (int n = 0; n < 20 && !b_done; n++) begin
            if (b_valid) begin resp = b_resp; b_done = 1'b1; end
            @(negedge clock);
        end
        b_ready = 1'b0;
        ok = aw_done && w_done && b_done;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output logic ok);
        logic ar_done, r_done;
        ar_done = 1'b0;
        r_done  = 1'b0;
        data    = 32'hxxxx_xxxx;
        resp    = 2'b11;
        ar_addr  = addr;
        ar_valid = 1'b1;
        for (int n = 0; n < 20 && !ar_done; n++) begin
            logic ar_f;
            ar_f = ar_valid && ar_ready;
            @(negedge clock);
            if (ar_f) begin ar_done = 1'b1; ar_valid = 1'b0; end
        end
        ar_valid = 1'b0;
        r_ready  = 1'b1;
        for (int n = 0; n < 20 && !r_done; n++) begin
            if (r_valid) begin data = r_data; resp = r_resp; r_done = 1'b1; end
            @(negedge clock);
        end
        r_ready = 1'b0;
        ok = ar_done && r_done;
    endtask

    logic [31:0] rd_cap;
    logic [1:0]  resp_cap, bresp_cap;
    logic        ok, got_b, got_r, seen;
    int unsigned wr0, rd0;

    initial begin
        n_vectors = 0;
        n_miscompares = 0;
        reset = 1'b1;
        {aw_valid, w_valid, b_ready, ar_valid, r_ready} = '0;
        {x_aw_valid, x_w_valid, x_b_ready, x_ar_valid, x_r_ready} = '0;
        aw_addr = '0; ar_addr = '0; w_data = '0; w_strb = '0;
        x_aw_addr = '0; x_ar_addr = '0; x_w_data = '0; x_w_strb = '0;

        vecs[0]  = '{1'b1, 32'h8000_0100, 32'hA5A5_5A5A, 4'hF, RESP_OKAY,   32'h0,         1, 0};
        vecs[1]  = '{1'b0, 32'h8000_0100, 32'h0,         4'h0, RESP_OKAY,   32'hA5A5_5A5A, 0, 1};
        vecs[2]  = '{1'b1, 32'h8000_0100, 32'h1234_5678, 4'h8, RESP_OKAY,   32'h0,         1, 0};
        vecs[3]  = '{1'b0, 32'h8000_0102, 32'h0,         4'h0, RESP_OKAY,   32'h12A5_5A5A, 0, 1};
        vecs[4]  = '{1'b1, 32'h8000_0104, 32'hCAFE_F00D, 4'h5, RESP_OKAY,   32'h0,         1, 0};
        vecs[5]  = '{1'b0, 32'h8000_0104, 32'h0,         4'h0, RESP_OKAY,   32'h00FE_000D, 0, 1};
        vecs[6]  = '{1'b0, 32'h87FF_FFFC, 32'h0,         4'h0, RESP_OKAY,   32'h0,         0, 1};
        vecs[7]  = '{1'b1, 32'h8800_0000, 32'hFFFF_FFFF, 4'hF, RESP_SLVERR, 32'h0,         0, 0};
        vecs[8]  = '{1'b0, 32'h8800_0000, 32'h0,         4'h0, RESP_SLVERR, 32'h0,         0, 0};
        vecs[9]  = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, RESP_SLVERR, 32'h0,         0, 0};
        vecs[10] = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, RESP_SLVERR, 32'h0,         0, 0};
        vecs[11] = '{1'b1, 32'h9000_0000, 32'h1357_9BDF, 4'hF, RESP_SLVERR, 32'h0,         0, 0};
        vecs[12] = '{1'b1, 32'h87FF_FFFC, 32'h0BAD_CAFE, 4'hF, RESP_OKAY,   32'h0,         1, 0};
        vecs[13] = '{1'b0, 32'h87FF_FFFE, 32'h0,         4'h0, RESP_OKAY,   32'h0BAD_CAFE, 0, 1};
        vecs[14] = '{1'b1, 32'h8000_0010, 32'h0F0E_0D0C, 4'hF, RESP_OKAY,   32'h0,         1, 0};
        vecs[15] = '{1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, RESP_OKAY,   32'h0,         1, 0};

        // Reset state, sampled while reset is still high.
        repeat (2) @(negedge clock);
        check("rst_aw_ready", 64'(aw_ready), 64'h0);
        check("rst_w_ready", 64'(w_ready), 64'h0);
        check("rst_ar_ready", 64'(ar_ready), 64'h0);
        check("rst_valids", 64'({b_valid, r_valid, x_b_valid, x_r_valid}), 64'h0);
        check("rst_resps", 64'({b_resp, r_resp, x_b_resp, x_r_resp}), 64'h0);
        check("rst_r_data", 64'(r_data), 64'h0);
        check("rst_x_r_data", x_r_data, 64'h0);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_readies", 64'({aw_ready, w_ready, ar_ready, x_aw_ready, x_ar_ready}),
              64'h1F);

        for (int i = 0; i < NVEC; i++) begin
            wr0 = pmem_wr_calls;
            rd0 = pmem_rd_calls;
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp_cap, ok);
            end else begin
                axi_read(vecs[i].addr, rd_cap, resp_cap, ok);
                check($sformatf("v%0d_rdata", i), 64'(rd_cap), 64'(vecs[i].exp_data));
            end
            check($sformatf("v%0d_done", i), 64'(ok), 64'h1);
            check($sformatf("v%0d_resp", i), 64'(resp_cap), 64'(vecs[i].exp_resp));
            check($sformatf("v%0d_wr_calls", i), 64'(pmem_wr_calls - wr0),
                  64'(vecs[i].exp_wr_inc));
            check($sformatf("v%0d_rd_calls", i), 64'(pmem_rd_calls - rd0),
                  64'(vecs[i].exp_rd_inc));
        end

        // Read latency 3 and r_data stability under back-pressure.
        ar_addr  = 32'h8000_0010;
        ar_valid = 1'b1;
        check("lat_ar_ready", 64'(ar_ready), 64'h1);
        @(negedge clock);
        ar_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("lat_r_valid_c%0d", k), 64'(r_valid), 64'(k == 3));
            if (k < 3) @(negedge clock);
        end
        check("lat_r_resp", 64'(r_resp), 64'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check($sformatf("stall_r_data_%0d", k), 64'({r_valid, r_data}), 64'h1_0F0E_0D0C);
        end
        r_ready = 1'b1;
        @(negedge clock);
        r_ready = 1'b0;
        check("lat_r_done", 64'({r_valid, ar_ready}), 64'h1);

        // W two cycles ahead of AW; WR_LATENCY is 2.
        w_data  = 32'hDEAD_BEEF;
        w_strb  = 4'b0011;
        w_valid = 1'b1;
        @(negedge clock);
        w_valid = 1'b0;
        check("wfirst_readies", 64'({aw_ready, w_ready}), 64'h2);
        wr0 = pmem_wr_calls;
        @(negedge clock);
        check("wfirst_no_early_commit", 64'(pmem_wr_calls - wr0), 64'h0);
        aw_addr  = 32'h8000_0020;
        aw_valid = 1'b1;
        @(negedge clock);
        aw_valid = 1'b0;
        check("wfirst_commit", 64'(pmem_wr_calls - wr0), 64'h1);
        check("wfirst_b_c2", 64'(b_valid), 64'h0);
        @(negedge clock);
        check("wfirst_b_c3", 64'(b_valid), 64'h0);
        @(negedge clock);
        check("wfirst_b_c4", 64'({b_valid, b_resp}), 64'h4);
        @(negedge clock);
        check("wfirst_b_hold", 64'({b_valid, b_resp}), 64'h4);
        b_ready = 1'b1;
        @(negedge clock);
        b_ready = 1'b0;
        check("wfirst_b_done", 64'(b_valid), 64'h0);
        axi_read(32'h8000_0020, rd_cap, resp_cap, ok);
        check("wfirst_readback", 64'(rd_cap), 64'h1122_BEEF);

        // Same-cycle AW+W with AR to the same word on the commit edge.
        aw_addr = 32'h8000_0030;
        ar_addr = 32'h8000_0030;
        w_data  = 32'h600D_F00D;
        w_strb  = 4'hF;
        {aw_valid, w_valid, ar_valid} = 3'b111;
        @(negedge clock);
        {aw_valid, w_valid, ar_valid} = 3'b000;
        b_ready = 1'b1;
        r_ready = 1'b1;
        got_b = 1'b0;
        got_r = 1'b0;
        for (int n = 0; n < 20 && !(got_b && got_r); n++) begin
            if (b_valid && !got_b) begin got_b = 1'b1; bresp_cap = b_resp; end
            if (r_valid && !got_r) begin got_r = 1'b1; rd_cap = r_data; resp_cap = r_resp; end
            @(negedge clock);
        end
        b_ready = 1'b0;
        r_ready = 1'b0;
        check("same_edge_got", 64'({got_b, got_r}), 64'h3);
        check("same_edge_rdata", 64'(rd_cap), 64'h600D_F00D);
        check("same_edge_resps", 64'({bresp_cap, resp_cap}), 64'h0);

        // Reset while the write sits in W_WAIT and the read in R_WAIT.
        aw_addr = 32'h8000_0040;
        w_data  = 32'h7777_7777;
        ar_addr = 32'h8000_0010;
        {aw_valid, w_valid, ar_valid} = 3'b111;
        @(negedge clock);
        {aw_valid, w_valid, ar_valid} = 3'b000;
        b_ready = 1'b1;
        r_ready = 1'b1;
        reset   = 1'b1;
        @(negedge clock);
        check("mid_rst_readies", 64'({aw_ready, w_ready, ar_ready}), 64'h0);
        reset = 1'b0;
        @(negedge clock);
        check("mid_rst_after_readies", 64'({aw_ready, w_ready, ar_ready}), 64'h7);
        seen = b_valid || r_valid;
        repeat (6) begin
            @(negedge clock);
            if (b_valid || r_valid) seen = 1'b1;
        end
        check("mid_rst_no_resp", 64'(seen), 64'h0);
        b_ready = 1'b0;
        r_ready = 1'b0;

        // A held W dropped by reset must never commit.
        w_data  = 32'h9999_9999;
        w_valid = 1'b1;
        @(negedge clock);
        w_valid = 1'b0;
        wr0 = pmem_wr_calls;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        aw_addr  = 32'h8000_0044;
        aw_valid = 1'b1;
        @(negedge clock);
        aw_valid = 1'b0;
        check("drop_w_no_commit", 64'(pmem_wr_calls - wr0), 64'h0);
        check("drop_w_readies", 64'({aw_ready, w_ready}), 64'h1);
        w_data  = 32'h55AA_55AA;
        w_valid = 1'b1;
        @(negedge clock);
        w_valid = 1'b0;
        b_ready = 1'b1;
        repeat (3) @(negedge clock);
        b_ready = 1'b0;
        check("drop_w_mem", 64'(pmem_peek(32'h8000_0044)), 64'h55AA_55AA);

        // 64-bit instance: strb F0 issues only the high-word call.
        x_aw_addr = 32'h8000_0008;
        x_w_data  = 64'h1122_3344_5566_7788;
        x_w_strb  = 8'hF0;
        x_aw_valid = 1'b1;
        x_w_valid  = 1'b1;
        wr0 = pmem_wr_calls;
        @(negedge clock);
        x_aw_valid = 1'b0;
        x_w_valid  = 1'b0;
        check("w64_calls", 64'(pmem_wr_calls - wr0), 64'h1);
        check("w64_hi_word", 64'(pmem_peek(32'h8000_000C)), 64'h1122_3344);
        check("w64_lo_word", 64'(pmem_peek(32'h8000_0008)), 64'h0);
        check("w64_b_early", 64'(x_b_valid), 64'h0);
        @(negedge clock);
        check("w64_b", 64'({x_b_valid, x_b_resp}), 64'h4);
        x_b_ready = 1'b1;
        @(negedge clock);
        x_b_ready = 1'b0;
        x_ar_addr  = 32'h8000_000C;
        x_ar_valid = 1'b1;
        rd0 = pmem_rd_calls;
        @(negedge clock);
        x_ar_valid = 1'b0;
        check("r64_calls", 64'(pmem_rd_calls - rd0), 64'h2);
        check("r64_r_early", 64'(x_r_valid), 64'h0);
        @(negedge clock);
        check("r64_r_valid", 64'({x_r_valid, x_r_resp}), 64'h4);
        check("r64_r_data", x_r_data, 64'h1122_3344_0000_0000);
        x_r_ready = 1'b1;
        @(negedge clock);
        x_r_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
